// File: rtl/viterbi_decoder_simple_v2.sv
`default_nettype none
// ============================================================================
// Module      : viterbi_decoder_simple_v2
// Description : Hard-decision rate-1/2 frame Viterbi decoder. One ACS step
//               per cycle over a parallel symbol array, then traceback from
//               the best end state into a parallel decoded-bit array.
// Revision    : 1.0 - initial release
// ============================================================================
module viterbi_decoder_simple_v2 #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [1:0] syms_in  [0:255],
  output logic       done,
  output logic [7:0] out_len,
  output logic       bits_out [0:255]
);

  localparam int M = K - 1;
  localparam int S = 1 << M;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACS  = 3'd1,
    BEST = 3'd2,
    TB   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state;
  state_t       state_d;
  logic [7:0]   t;
  logic [7:0]   tb_t;
  logic [7:0]   frame_len_q;
  logic [7:0]   out_len_q;
  logic [M-1:0] cur_q;
  logic [11:0]  pm_q     [0:S-1];
  logic         bits_q   [0:255];
  logic [S-1:0] surv_q   [0:255];

  logic [1:0]   w_sym;
  logic [11:0]  w_pm_new [0:S-1];
  logic [S-1:0] w_surv;
  logic [M-1:0] w_best;
  logic [11:0]  w_best_pm;
  logic         w_start_ok;

  assign w_sym      = syms_in[t];
  assign w_start_ok = start && ((state == IDLE) || (state == DONE));

  // One add-compare-select unit per next state; predecessor b=0 wins ties.
  for (genvar n = 0; n < S; n++) begin : g_acs
    localparam int           P0I = n / 2;
    localparam int           P1I = n / 2 + S / 2;
    localparam logic [K-1:0] R0  = K'(2 * P0I + n % 2);
    localparam logic [K-1:0] R1  = K'(2 * P1I + n % 2);
    localparam logic [1:0]   E0  = {^(R0 & G0), ^(R0 & G1)};
    localparam logic [1:0]   E1  = {^(R1 & G0), ^(R1 & G1)};

    logic [1:0]  w_d0;
    logic [1:0]  w_d1;
    logic [11:0] w_m0;
    logic [11:0] w_m1;

    assign w_d0        = w_sym ^ E0;
    assign w_d1        = w_sym ^ E1;
    assign w_m0        = pm_q[P0I] + {11'd0, w_d0[1]} + {11'd0, w_d0[0]};
    assign w_m1        = pm_q[P1I] + {11'd0, w_d1[1]} + {11'd0, w_d1[0]};
    assign w_surv[n]   = (w_m1 < w_m0);
    assign w_pm_new[n] = (w_m1 < w_m0) ? w_m1 : w_m0;
  end

  // Minimum path metric, lowest state index on a tie.
  always_comb begin
    w_best    = '0;
    w_best_pm = pm_q[0];
    for (int i = 1; i < S; i++) begin
      if (pm_q[i] < w_best_pm) begin
        w_best_pm = pm_q[i];
        w_best    = i[M-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // FSM next-state logic; a zero-length frame skips straight to DONE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (w_start_ok) state_d = (frame_len == 8'd0) ? DONE : ACS;
      ACS:        if (t == frame_len_q - 8'd1) state_d = BEST;
      BEST:       state_d = TB;
      TB:         if (tb_t == 8'd0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath: metric init, ACS update, best-state pick and traceback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t           <= 8'd0;
      tb_t        <= 8'd0;
      frame_len_q <= 8'd0;
      out_len_q   <= 8'd0;
      cur_q       <= '0;
      for (int i = 0; i < S; i++)   pm_q[i]   <= 12'd0;
      for (int i = 0; i < 256; i++) bits_q[i] <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            frame_len_q <= frame_len;
            out_len_q   <= 8'd0;
            t           <= 8'd0;
            for (int i = 0; i < S; i++)   pm_q[i]   <= (i == 0) ? 12'd0 : 12'd1024;
            for (int i = 0; i < 256; i++) bits_q[i] <= 1'b0;
          end
        end
        ACS: begin
          for (int i = 0; i < S; i++) pm_q[i] <= w_pm_new[i];
          t <= t + 8'd1;
        end
        BEST: begin
          cur_q <= w_best;
          tb_t  <= frame_len_q - 8'd1;
        end
        TB: begin
          bits_q[tb_t] <= cur_q[0];
          cur_q        <= {surv_q[tb_t][cur_q], cur_q[M-1:1]};
          if (tb_t != 8'd0) tb_t      <= tb_t - 8'd1;
          else              out_len_q <= frame_len_q;
        end
        default: ;
      endcase
    end
  end

  // Survivor memory: row t captures the winning predecessor bit per state.
  always_ff @(posedge clk) begin
    if (state == ACS) surv_q[t] <= w_surv;
  end

  assign done     = (state == DONE);
  assign out_len  = out_len_q;
  assign bits_out = bits_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder_simple_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_viterbi_decoder_simple_v2
// Description : Directed self-checking bench for viterbi_decoder_simple_v2
//               with a reference encoder and an expected-bit scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_decoder_simple_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic [1:0] syms_in  [0:255];
  logic       done;
  logic [7:0] out_len;
  logic       bits_out [0:255];

  bit         msg [0:255];
  bit         exp_q [$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  viterbi_decoder_simple_v2 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .syms_in   (syms_in),
    .done      (done),
    .out_len   (out_len),
    .bits_out  (bits_out)
  );

  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ones_from(input int lo);
    int c = 0;
    for (int i = lo; i < 256; i++) c += int'(bits_out[i]);
    return c;
  endfunction

  // Reference encoder: r = {st,u}, c1 = ^(r&111), c0 = ^(r&101), st <= {st[0],u}.
  task automatic load_frame(input int len, input bit push);
    logic [1:0] st;
    logic [2:0] r;
    st = 2'b00;
    for (int i = 0; i < 256; i++) syms_in[i] = 2'b00;
    for (int i = 0; i < len; i++) begin
      r          = {st, msg[i]};
      syms_in[i] = {^(r & 3'b111), ^(r & 3'b101)};
      st         = {st[0], msg[i]};
      if (push) exp_q.push_back(msg[i]);
    end
    frame_len = len[7:0];
  endtask

  task automatic clear_msg();
    for (int i = 0; i < 256; i++) msg[i] = 1'b0;
  endtask

  // Pulse start, count cycles to done (bounded), then drain the scoreboard.
  task automatic run_frame(input string tag, input int len, input int exp_cycles, input bit poke);
    int cycles;
    bit e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cycles = 1;
    if (len > 0) check({tag, " state after start"}, 32'(dut.state), 32'd1);
    while (done !== 1'b1 && cycles < 1000) begin
      start = (poke && cycles == 10);
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    check({tag, " latency"}, cycles, exp_cycles);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " out_len"}, 32'(out_len), len);
    for (int i = 0; i < len; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      check($sformatf("%s bit%0d", tag, i), 32'(bits_out[i]), 32'(e));
    end
    check({tag, " bits beyond len"}, ones_from(len), 0);
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 256; i++) syms_in[i] = 2'b00;
    clear_msg();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset done", 32'(done), 0);
    check("reset out_len", 32'(out_len), 0);
    check("reset state", 32'(dut.state), 0);
    check("reset t", 32'(dut.t), 0);
    check("reset tb_t", 32'(dut.tb_t), 0);
    check("reset bits", ones_from(0), 0);

    // Single one at t=8
    clear_msg();
    msg[8] = 1'b1;
    load_frame(32, 1'b1);
    run_frame("one", 32, 66, 1'b0);

    // All-zero frame
    clear_msg();
    load_frame(16, 1'b1);
    run_frame("zero", 16, 34, 1'b0);

    // Single symbol error at t=20 (00 -> 01)
    clear_msg();
    msg[8] = 1'b1;
    load_frame(32, 1'b1);
    syms_in[20] = syms_in[20] ^ 2'b01;
    run_frame("err", 32, 66, 1'b0);

    // Random 100-bit message; a stray start during ACS must be ignored
    clear_msg();
    for (int i = 0; i < 100; i++) msg[i] = bit'($urandom_range(0, 1));
    load_frame(100, 1'b1);
    run_frame("rand", 100, 202, 1'b1);

    // Zero-length frame restarted from DONE
    load_frame(0, 1'b1);
    run_frame("len0", 0, 1, 1'b0);

    // Async reset during traceback, after bit 8 has been written
    clear_msg();
    msg[8] = 1'b1;
    load_frame(32, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!(32'(dut.state) == 32'd3 && dut.tb_t == 8'd5) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("abort reached TB", 32'(guard < 500), 1);
    check("abort bit8 before reset", 32'(bits_out[8]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort done", 32'(done), 0);
    check("abort bits", ones_from(0), 0);
    check("abort out_len", 32'(out_len), 0);
    check("abort state", 32'(dut.state), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fresh decode after the abort
    load_frame(32, 1'b1);
    run_frame("after", 32, 66, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
